// File: rtl/regfile_writeback_pkg.sv
// Shared encodings for the writeback stage: writeback source selects,
// load funct3 codes and the writeback FSM state type.
package regfile_writeback_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/regfile_writeback_load_align.sv
// Picks the byte/half/word out of a word-aligned load response and
// sign- or zero-extends it according to funct3.
module regfile_writeback_load_align
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[8*i_addr +: 8];
  // Misaligned halves fall back to the half selected by addr[1].
  assign w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];

  always_comb begin
    o_data = '0;
    unique case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   o_data = i_data;
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: selects ALU / load / pc+4, writes the register file,
// serves two bypassed read ports and stalls while a load is outstanding.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  input  logic [4:0]      inRd,
  input  logic            inRegWrite,
  input  logic [1:0]      inWbSel,
  input  logic [XLEN-1:0] inAluResult,
  input  logic [XLEN-1:0] inPc,
  input  logic [2:0]      inFunct3,
  input  logic            memRespValid,
  input  logic [XLEN-1:0] memRespData,
  output logic            stall,
  input  logic [4:0]      rs1Addr,
  input  logic [4:0]      rs2Addr,
  output logic [XLEN-1:0] rs1Val,
  output logic [XLEN-1:0] rs2Val,
  output logic            wbValid,
  output logic [4:0]      wbRd,
  output logic [XLEN-1:0] wbData
);

  wb_state_e       r_state;
  wb_state_e       w_state_next;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr;

  logic            w_latch;
  logic            w_stall;
  logic            w_wb_valid;
  logic [4:0]      w_wb_rd;
  logic [XLEN-1:0] w_wb_data;
  logic [2:0]      w_align_f3;
  logic [1:0]      w_align_addr;
  logic [XLEN-1:0] w_align_data;

  // While waiting, alignment uses the fields captured when the load retired.
  assign w_align_f3   = (r_state == ST_WAIT_LOAD) ? r_funct3 : inFunct3;
  assign w_align_addr = (r_state == ST_WAIT_LOAD) ? r_addr : inAluResult[1:0];

  regfile_writeback_load_align #(.XLEN(XLEN)) u_load_align (
    .i_data   (memRespData),
    .i_funct3 (w_align_f3),
    .i_addr   (w_align_addr),
    .o_data   (w_align_data)
  );

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_latch      = 1'b0;
    w_wb_valid   = 1'b0;
    w_wb_rd      = inRd;
    w_wb_data    = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (inValid) begin
          unique case (inWbSel)
            WB_ALU: begin
              w_wb_data  = inAluResult;
              w_wb_valid = inRegWrite && (inRd != 5'd0);
            end
            WB_PC4: begin
              w_wb_data  = inPc + XLEN'(4);
              w_wb_valid = inRegWrite && (inRd != 5'd0);
            end
            WB_LOAD: begin
              if (memRespValid) begin
                w_wb_data  = w_align_data;
                w_wb_valid = inRegWrite && (inRd != 5'd0);
              end else begin
                w_stall      = 1'b1;
                w_latch      = 1'b1;
                w_state_next = ST_WAIT_LOAD;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_LOAD: begin
        w_wb_rd = r_rd;
        if (memRespValid) begin
          w_wb_data    = w_align_data;
          w_wb_valid   = r_reg_write && (r_rd != 5'd0);
          w_state_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= ST_IDLE;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_rd        <= inRd;
        r_reg_write <= inRegWrite;
        r_funct3    <= inFunct3;
        r_addr      <= inAluResult[1:0];
      end
    end
  end

  // x0 is never written because w_wb_valid excludes rd == 0.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_valid) begin
      r_regs[w_wb_rd] <= w_wb_data;
    end
  end

  assign stall   = w_stall;
  assign wbValid = w_wb_valid;
  assign wbRd    = w_wb_valid ? w_wb_rd : 5'd0;
  assign wbData  = w_wb_valid ? w_wb_data : '0;

  assign rs1Val = (rs1Addr == 5'd0) ? '0 :
                  (w_wb_valid && (w_wb_rd == rs1Addr)) ? w_wb_data : r_regs[rs1Addr];
  assign rs2Val = (rs2Addr == 5'd0) ? '0 :
                  (w_wb_valid && (w_wb_rd == rs2Addr)) ? w_wb_data : r_regs[rs2Addr];

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized scoreboard bench for regfile_writeback: stimulus pushes expected
// writebacks computed from a register-array model; a monitor pops and compares.
module tb_regfile_writeback;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic [4:0]  inRd;
  logic        inRegWrite;
  logic [1:0]  inWbSel;
  logic [31:0] inAluResult;
  logic [31:0] inPc;
  logic [2:0]  inFunct3;
  logic        memRespValid;
  logic [31:0] memRespData;
  logic        stall;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Val;
  logic [31:0] rs2Val;
  logic        wbValid;
  logic [4:0]  wbRd;
  logic [31:0] wbData;

  regfile_writeback dut (
    .clk          (clk),
    .rstN         (rstN),
    .inValid      (inValid),
    .inRd         (inRd),
    .inRegWrite   (inRegWrite),
    .inWbSel      (inWbSel),
    .inAluResult  (inAluResult),
    .inPc         (inPc),
    .inFunct3     (inFunct3),
    .memRespValid (memRespValid),
    .memRespData  (memRespData),
    .stall        (stall),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .rs1Val       (rs1Val),
    .rs2Val       (rs2Val),
    .wbValid      (wbValid),
    .wbRd         (wbRd),
    .wbData       (wbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Outstanding-load bookkeeping for the reference model.
  bit          pend;
  logic [4:0]  p_rd;
  bit          p_rw;
  logic [2:0]  p_f3;
  logic [1:0]  p_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd2:    return d;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  // One pipeline cycle: drive just after the rising edge, check at the falling edge.
  task automatic step(input bit v, input logic [4:0] rd, input bit rw, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                      input bit rv, input logic [31:0] rdata,
                      input logic [4:0] a1, input logic [4:0] a2);
    bit          exp_v;
    bit          exp_stall;
    logic [4:0]  exp_rd;
    logic [31:0] exp_d;
    @(posedge clk);
    #1;
    inValid = v; inRd = rd; inRegWrite = rw; inWbSel = sel; inAluResult = alu;
    inPc = pc; inFunct3 = f3; memRespValid = rv; memRespData = rdata;
    rs1Addr = a1; rs2Addr = a2;
    exp_v = 0; exp_stall = 0; exp_rd = rd; exp_d = 32'd0;
    if (!pend) begin
      if (v) begin
        case (sel)
          2'd0: begin exp_d = alu;        exp_v = rw && (rd != 0); end
          2'd2: begin exp_d = pc + 32'd4; exp_v = rw && (rd != 0); end
          2'd1: begin
            if (rv) begin
              exp_d = ref_load(rdata, f3, alu[1:0]);
              exp_v = rw && (rd != 0);
            end else begin
              pend = 1; p_rd = rd; p_rw = rw; p_f3 = f3; p_a = alu[1:0];
              exp_stall = 1;
            end
          end
          default: ;
        endcase
      end
    end else begin
      exp_rd = p_rd;
      if (rv) begin
        exp_d = ref_load(rdata, p_f3, p_a);
        exp_v = p_rw && (p_rd != 0);
        pend  = 0;
      end else begin
        exp_stall = 1;
      end
    end
    if (exp_v) begin
      model[exp_rd] = exp_d;
      sb_q.push_back('{rd: exp_rd, data: exp_d});
    end
    @(negedge clk);
    chk("stall", {31'd0, stall}, {31'd0, exp_stall});
    chk("wb_valid", {31'd0, wbValid}, {31'd0, exp_v});
    chk("rs1_read", rs1Val, model[a1]);
    chk("rs2_read", rs2Val, model[a2]);
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [31:0] lit, input string name);
    step(0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0, a1, 5'd0);
    chk(name, rs1Val, lit);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstN = 1'b0;
    inValid = 0; memRespValid = 0;
    pend = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb_valid", {31'd0, wbValid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wbRd}, 32'd0);
    chk("rst_wb_data", wbData, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rstN = 1'b1;
  endtask

  // Monitor: every presented writeback is matched against the scoreboard.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rstN && wbValid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got rd=%0d data=0x%08h expected no write", wbRd, wbData);
        end else begin
          e = sb_q.pop_front();
          $display("wb rd=%0d data=0x%08h (expected rd=%0d data=0x%08h)", wbRd, wbData, e.rd, e.data);
          chk("wb_rd", {27'd0, wbRd}, {27'd0, e.rd});
          chk("wb_data", wbData, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [7];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    rstN = 1'b0; inValid = 0; inRd = 0; inRegWrite = 0; inWbSel = 0; inAluResult = 0;
    inPc = 0; inFunct3 = 0; memRespValid = 0; memRespData = 0; rs1Addr = 0; rs2Addr = 0;
    pend = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    do_reset();

    for (int i = 1; i < 32; i++)
      step(0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 0, 5'(i), 5'(32 - i));

    step(1, 5, 1, 2'd0, 32'hDEADBEEF, 0, 3'd0, 0, 0, 5, 0);
    chk("alu_bypass", rs1Val, 32'hDEADBEEF);
    idle_read(5, 32'hDEADBEEF, "alu_array");

    step(1, 0, 1, 2'd0, 32'h1234, 0, 3'd0, 0, 0, 0, 0);
    chk("x0_no_wb", {31'd0, wbValid}, 32'd0);
    chk("x0_read", rs1Val, 32'd0);

    step(1, 1, 1, 2'd0, 32'h55, 0, 3'd0, 0, 0, 1, 0);
    step(1, 1, 1, 2'd2, 0, 32'hFFFFFFFC, 3'd0, 0, 0, 1, 0);
    idle_read(1, 32'h0, "jal_wrap");

    step(1, 10, 1, 2'd1, 32'h3, 0, 3'd0, 1, 32'h80FF7F01, 10, 0);
    idle_read(10, 32'hFFFFFF80, "lb_a3");
    step(1, 11, 1, 2'd1, 32'h3, 0, 3'd4, 1, 32'h80FF7F01, 11, 0);
    idle_read(11, 32'h00000080, "lbu_a3");
    step(1, 12, 1, 2'd1, 32'h2, 0, 3'd1, 1, 32'h80FF7F01, 12, 0);
    idle_read(12, 32'hFFFF80FF, "lh_a2");
    step(1, 13, 1, 2'd1, 32'h0, 0, 3'd5, 1, 32'h80FF7F01, 13, 0);
    idle_read(13, 32'h00007F01, "lhu_a0");
    step(1, 14, 1, 2'd1, 32'h0, 0, 3'd2, 1, 32'h80FF7F01, 14, 0);
    idle_read(14, 32'h80FF7F01, "lw");

    // Load abandoned by reset: the late response must not write x7.
    step(1, 7, 1, 2'd1, 32'h0, 0, 3'd2, 0, 0, 7, 0);
    step(1, 7, 1, 2'd1, 32'h0, 0, 3'd2, 0, 0, 7, 0);
    do_reset();
    step(0, 7, 1, 2'd1, 32'h0, 0, 3'd2, 1, 32'hCAFEF00D, 7, 0);
    idle_read(7, 32'h0, "abort_x7");

    // Three-cycle delayed response.
    for (int i = 0; i < 3; i++)
      step(1, 7, 1, 2'd1, 32'h0, 0, 3'd2, 0, 0, 7, 0);
    step(1, 7, 1, 2'd1, 32'h0, 0, 3'd2, 1, 32'hCAFEF00D, 7, 0);
    chk("delay_rsp_stall", {31'd0, stall}, 32'd0);
    idle_read(7, 32'hCAFEF00D, "delay_x7");

    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 7) != 0,
           2'($urandom_range(0, 3)), $urandom, $urandom, f3_tab[$urandom_range(0, 6)],
           $urandom_range(0, 1) == 1, $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    step(0, 0, 0, 2'd0, 0, 0, 3'd0, 1, 32'h1, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback end of the integer pipeline. It retires one instruction per cycle from the memory stage and selects the writeback value: ALU result, aligned load data, or pc+4.
- Writes that value into the 32x32 architectural register file.
- Serves the two decode read ports (rs1Val/rs2Val) that feed the ALU operand muxes, with write-through bypass.
- Stalls the pipeline while a load's memory response is outstanding.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  pipeline clock.
- rstN  in  1  asynchronous active-low reset.
- inValid  in  1  memory stage presents a retiring instruction.
- inRd  in  5  destination register.
- inRegWrite  in  1  instruction writes rd.
- inWbSel  in  2  writeback source: 00 ALU, 01 load, 10 pc+4, 11 reserved (no write).
- inAluResult  in  XLEN  ALU result; for loads, the effective address.
- inPc  in  XLEN  instruction pc.
- inFunct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- memRespValid  in  1  load data valid this cycle.
- memRespData  in  XLEN  word-aligned load data.
- stall  out  1  upstream must hold; inputs are not accepted.
- rs1Addr, rs2Addr  in  5 each  decode read addresses.
- rs1Val, rs2Val  out  XLEN each  read data, combinational.
- wbValid  out  1  register write occurring this cycle (for forwarding).
- wbRd  out  5  register written this cycle.
- wbData  out  XLEN  value written this cycle.

Behaviour:
- Reset (rstN low, asynchronous): all registers clear to 0; FSM goes to IDLE; pending latch clears; stall, wbValid, wbRd and wbData are all 0.
- FSM states are IDLE and WAIT_LOAD.
- IDLE, inValid with inWbSel != 01:
  - Same cycle: wbData = inAluResult (sel 00) or inPc+4 (sel 10, mod 2^XLEN).
  - wbValid = inRegWrite & (inRd != 0) & (inWbSel != 11).
  - Array written at the clock edge.
- IDLE, inValid with inWbSel == 01:
  - If memRespValid is high in the same cycle, complete immediately as below; no stall.
  - Otherwise latch rd, regWrite, funct3 and addr[1:0]; go to WAIT_LOAD; stall = 1 combinationally in that cycle.
- WAIT_LOAD: stall = 1 until memRespValid.
  - In the response cycle: stall = 0, wbValid asserted and data written using the latched fields; return to IDLE.
  - inValid is ignored while stall = 1.
- Load alignment:
  - Byte = memRespData[8*addr+7 : 8*addr].
  - Half = memRespData[16*addr[1]+15 : 16*addr[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
  - Misaligned half/word accesses use addr[1] (half) or ignore addr (word); no trap.
  - Unsupported funct3 values produce wbData = 0 with the write still performed.
- Read ports:
  - rsXVal = 0 when rsXAddr == 0.
  - Else if wbValid and wbRd == rsXAddr, rsXVal = wbData (same-cycle bypass).
  - Else rsXVal = the array value.
- Writes to x0 are never performed and never bypassed.
- memRespValid in IDLE without a pending load is ignored.
- Reset asserted mid-WAIT_LOAD abandons the load; no write occurs.

Decomposition:
- Shared package holds:
  - WB_ALU, WB_LOAD, WB_PC4 select encodings, shared with the decoder.
  - Load funct3 constants.
  - The IDLE/WAIT_LOAD state enum.
- Sub-module load_align: combinational alignment and extension of (data, funct3, addr[1:0]).
- Register array, FSM and bypass stay in the top module.

Test Plan:
- Reset release, read x1..x31 -> all 0; stall = 0; wbValid = 0.
- ALU write: rd=5, sel 00, result 0xDEADBEEF, rs1Addr=5 in the same cycle -> rs1Val = 0xDEADBEEF (bypass); next cycle rs1Val is still 0xDEADBEEF from the array.
- Write to x0: rd=0, value 0x1234 -> wbValid = 0; rs1Addr=0 reads 0.
- JAL writeback: sel 10, pc=0xFFFFFFFC -> x1 = 0x00000000 (wrap).
- Loads with memRespData = 0x80FF7F01:
  - LB addr[1:0]=3 -> 0xFFFFFF80.
  - LBU addr 3 -> 0x00000080.
  - LH addr 2 -> 0xFFFF80FF.
  - LHU addr 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Delayed response: load to rd=7, memRespValid low for 3 cycles -> stall high for exactly those 3 cycles; x7 written in the response cycle with stall low.
  - Variant: assert rstN low during the wait -> x7 remains 0 and the FSM returns to IDLE.
